// File: rtl/fetch_queue.sv
// fetch_queue: PC generator, single-outstanding instruction memory reader and
// small instruction FIFO feeding decode over a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch at a new word-aligned PC.
// Optional build macro FETCH_QUEUE_PERF_EN adds the stall_cnt output, which
// counts cycles with no instruction presented to decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Request gating, FIFO handshakes and head presentation.
  always_comb begin
    imem_req  = !rst && (state == IDLE) && (count < FULL) && !redirect;
    imem_addr = (state == IDLE) ? fetch_pc : req_pc;
    push      = (state == WAIT) && imem_valid && !redirect;
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    out_inst  = out_valid ? inst_mem[head] : '0;
    out_pc    = out_valid ? pc_mem[head] : '0;
  end

  // Fetch FSM: redirect overrides everything; a response that races a
  // redirect is dropped, otherwise the outstanding one is drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      case (state)
        WAIT:    state <= imem_valid ? IDLE : DRAIN;
        DRAIN:   state <= imem_valid ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (imem_req) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT:    if (imem_valid) state <= IDLE;
        DRAIN:   if (imem_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: instruction word tagged with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= imem_rdata;
      pc_mem[tail]   <= req_pc;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Saturating count of cycles with nothing presented to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!out_valid && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a behavioural memory with configurable latency,
// directed scenarios, then randomized ready/redirect/reset traffic. A
// scoreboard holds the expected next PC of the sequential stream and a
// monitor compares every instruction decode accepts.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          latency  = 1;
  bit          pending  = 1'b0;
  int          cnt      = 0;
  logic [31:0] pend_addr = '0;
  bit          resp_next = 1'b0;
  int          pops     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;

  fetch_queue #(
    .DEPTH   (4),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: a bijective scramble of the address, word 0 = 00500113.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h00500113 ^ (a * 32'h9E3779B1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory request capture; latency L means the response strobe arrives L
  // cycles after the request cycle.
  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
    end else if (imem_req === 1'b1) begin
      check("one_outstanding", {31'd0, pending}, 32'd0);
      check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      pending   = 1'b1;
      cnt       = latency - 1;
      pend_addr = imem_addr;
    end
    resp_next = pending && (cnt == 0);
  end

  // Memory response driver.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      if (!rst && pending) begin
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = word_at(pend_addr);
          pending    = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Scoreboard monitor: accepted instructions must follow the sequential
  // stream from the last reset/redirect target.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RESET_PC);
    end else begin
      if (out_valid !== 1'b1) begin
        check("empty_inst", out_inst, 32'd0);
        check("empty_pc", out_pc, 32'd0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got pc %h expected none", out_pc);
        end else begin
          sb_e = exp_q.pop_front();
          check("out_pc", out_pc, sb_e);
          check("out_inst", out_inst, word_at(sb_e));
          exp_q.push_back(sb_e + 32'd4);
          pops++;
        end
      end
      if (redirect) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input int maxc, input string name, input logic [31:0] addr);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      sample();
    end
    if (ok) check(name, imem_addr, addr);
    else begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no request expected addr %h within %0d cycles", name, addr, maxc);
    end
  endtask

  initial begin
    int cycles;
    bit found;
    rst = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; latency = 1;
    repeat (3) tick();
    sample();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_pc", out_pc, 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
    check("rst_stall", stall_cnt, 32'd0);
`endif

    // First fetch with a 1-cycle memory.
    tick(); rst = 1'b0;
    sample();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    tick(); sample();
    check("wait_noreq", {31'd0, imem_req}, 32'd0);
    check("nobypass", {31'd0, out_valid}, 32'd0);
    tick(); sample();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_inst", out_inst, 32'h00500113);
    check("first_pc", out_pc, 32'd0);
    check("second_req", {31'd0, imem_req}, 32'd1);
    check("second_addr", imem_addr, 32'd4);
`ifdef FETCH_QUEUE_PERF_EN
    check("stall_first", stall_cnt, 32'd2);
`endif

    // Fill to capacity with decode stalled, then drain.
    repeat (10) begin tick(); sample(); end
    check("full_noreq", {31'd0, imem_req}, 32'd0);
    check("full_head", out_pc, 32'd0);
    tick(); out_ready = 1'b1;
    sample();
    wait_req(10, "resume_addr", 32'd16);

    // Latency-3 memory: address held, one request per 4 cycles.
    latency = 3;
    tick(); sample();
    wait_req(10, "lat3_req", 32'd20);
    for (int j = 0; j < 3; j++) begin
      tick(); sample();
      check("lat3_noreq", {31'd0, imem_req}, 32'd0);
      check("lat3_addr", imem_addr, 32'd20);
    end
    tick(); sample();
    check("lat3_period", {31'd0, imem_req}, 32'd1);
    check("lat3_next", imem_addr, 32'd24);

    // Redirect while a request is outstanding; stale word arrives later.
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0043;
    sample();
    tick(); redirect = 1'b0;
    sample();
    check("flush_empty", {31'd0, out_valid}, 32'd0);
    check("drain_noreq", {31'd0, imem_req}, 32'd0);
    tick(); sample();
    check("drain_stale", {31'd0, imem_req}, 32'd0);
    tick(); sample();
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0040);

    // Redirect coinciding with a response and a pop.
    latency = 2; out_ready = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (out_valid && resp_next) begin found = 1'b1; break; end
      tick(); sample();
    end
    check("race_setup", {31'd0, found}, 32'd1);
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0100; out_ready = 1'b1;
    sample();
    tick(); redirect = 1'b0; out_ready = 1'b0;
    sample();
    check("race_empty", {31'd0, out_valid}, 32'd0);
    check("race_req", {31'd0, imem_req}, 32'd1);
    check("race_addr", imem_addr, 32'h0000_0100);

    // Address wrap at the top of the address space.
    out_ready = 1'b1;
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    sample();
    tick(); redirect = 1'b0;
    sample();
    wait_req(10, "wrap_first", 32'hFFFF_FFFC);
    tick(); sample();
    wait_req(10, "wrap_second", 32'h0);

    // Mid-run reset, then first-valid timing with a 2-cycle memory.
    tick(); rst = 1'b1; latency = 2; out_ready = 1'b0;
    tick(); rst = 1'b0;
    sample();
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 10) begin
      tick(); sample();
      cycles++;
    end
    check("lat2_first_valid", cycles, 32'd3);
`ifdef FETCH_QUEUE_PERF_EN
    check("stall_lat2", stall_cnt, 32'd3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst         = ($urandom_range(0, 399) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      latency     = $urandom_range(1, 4);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      sample();
    end
    tick(); rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    repeat (20) begin tick(); sample(); end
    check("liveness", {31'd0, (pops > 300)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
